// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: opcodes, ALU funct3 encodings and the registered ALU request shared by the issue stage and the ALU.
package alu_issue_pkg;
    localparam int XLEN_MAX = 64;
    localparam int ADDR_MAX = 8;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SL   = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } alu_funct3_e;
    // Sized for the widest build; narrower builds keep the upper bits at zero.
    typedef struct packed {
        logic [2:0]          funct3;
        logic                invert;
        logic [XLEN_MAX-1:0] op1;
        logic [XLEN_MAX-1:0] op2;
        logic [ADDR_MAX-1:0] rd;
        logic                illegal;
    } alu_req_t;
endpackage

// File: rtl/alu_issue_stage_operand_fwd_mux.sv
// operand_fwd_mux: source operand select with x0 zeroing and EX-over-WB forwarding priority.
module operand_fwd_mux #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] idx,
    input  logic [XLEN-1:0]       rf_data,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]       ex_data,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic [XLEN-1:0]       data
);
    always_comb begin
        data = idx == '0 ? '0 :
               (ex_valid && ex_rd == idx) ? ex_data :
               (wb_valid && wb_rd == idx) ? wb_data : rf_data;
    end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX stage resolving operands and ALU controls for OP, OP-IMM, LUI and AUIPC.
// Define ALU_ISSUE_FORWARD_EN for EX/WB forwarding; without it RAW hazards stall the input instead.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            in_opcode,
    input  logic [2:0]            in_funct3,
    input  logic                  in_funct7_b5,
    input  logic [REG_ADDR_W-1:0] in_rs1,
    input  logic [REG_ADDR_W-1:0] in_rs2,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [XLEN-1:0]       in_imm,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic                  ex_fwd_valid,
    input  logic [REG_ADDR_W-1:0] ex_fwd_rd,
    input  logic [XLEN-1:0]       ex_fwd_data,
    input  logic                  wb_fwd_valid,
    input  logic [REG_ADDR_W-1:0] wb_fwd_rd,
    input  logic [XLEN-1:0]       wb_fwd_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            out_funct3,
    output logic                  out_invert,
    output logic [XLEN-1:0]       out_operand_1,
    output logic [XLEN-1:0]       out_operand_2,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_illegal
);
`ifdef ALU_ISSUE_FORWARD_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif
    alu_req_t        req_d, req_q;
    logic            out_valid_d, out_valid_q;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            is_op, is_imm, is_lui, is_auipc, use_rs1, use_rs2;
    logic            raw_rs1, raw_rs2, hazard_stall, xfer;

    operand_fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_rs1_mux (
        .idx(in_rs1), .rf_data(rs1_data),
        .ex_valid(ex_fwd_valid & FWD_EN), .ex_rd(ex_fwd_rd), .ex_data(ex_fwd_data),
        .wb_valid(wb_fwd_valid & FWD_EN), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data),
        .data(rs1_val)
    );

    operand_fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_rs2_mux (
        .idx(in_rs2), .rf_data(rs2_data),
        .ex_valid(ex_fwd_valid & FWD_EN), .ex_rd(ex_fwd_rd), .ex_data(ex_fwd_data),
        .wb_valid(wb_fwd_valid & FWD_EN), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data),
        .data(rs2_val)
    );

    always_comb begin
        is_op        = in_opcode == OPC_OP;
        is_imm       = in_opcode == OPC_OP_IMM;
        is_lui       = in_opcode == OPC_LUI;
        is_auipc     = in_opcode == OPC_AUIPC;
        use_rs1      = is_op || is_imm;
        use_rs2      = is_op;
        raw_rs1      = in_rs1 != '0 && ((ex_fwd_valid && ex_fwd_rd == in_rs1) ||
                       (wb_fwd_valid && wb_fwd_rd == in_rs1) || (out_valid_q && out_rd == in_rs1));
        raw_rs2      = in_rs2 != '0 && ((ex_fwd_valid && ex_fwd_rd == in_rs2) ||
                       (wb_fwd_valid && wb_fwd_rd == in_rs2) || (out_valid_q && out_rd == in_rs2));
        hazard_stall = !FWD_EN && ((use_rs1 && raw_rs1) || (use_rs2 && raw_rs2));
        in_ready     = flush || ((!out_valid_q || out_ready) && !hazard_stall);
        xfer         = in_valid && in_ready && !flush;
        out_valid_d  = !flush && (xfer || (out_valid_q && !out_ready));
        req_d        = req_q;
        if (xfer) begin
            req_d.illegal = !(use_rs1 || is_lui || is_auipc);
            req_d.funct3  = use_rs1 ? in_funct3 : F3_ADD;
            req_d.invert  = !use_rs1 ? 1'b1 :
                            in_funct3 == F3_ADD ? (is_imm || !in_funct7_b5) :
                            (in_funct3 == F3_SR) && in_funct7_b5;
            req_d.op1     = XLEN_MAX'(is_auipc ? in_pc : use_rs1 ? rs1_val : '0);
            req_d.op2     = XLEN_MAX'(is_op ? rs2_val : (is_imm || is_lui || is_auipc) ? in_imm : '0);
            req_d.rd      = ADDR_MAX'(req_d.illegal ? '0 : in_rd);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            req_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            req_q       <= req_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) assert ((req_q.op1 >> XLEN) == '0 && (req_q.op2 >> XLEN) == '0 && (req_q.rd >> REG_ADDR_W) == '0);
    end

    assign out_valid     = out_valid_q;
    assign out_funct3    = req_q.funct3;
    assign out_invert    = req_q.invert;
    assign out_operand_1 = req_q.op1[XLEN-1:0];
    assign out_operand_2 = req_q.op2[XLEN-1:0];
    assign out_rd        = req_q.rd[REG_ADDR_W-1:0];
    assign out_illegal   = req_q.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed plus random stimulus against a queue scoreboard and a spec-level reference model.
module tb_alu_issue_stage;
    localparam int XLEN = 32;
    localparam int RW   = 5;

    typedef struct packed {
        logic [2:0]      f3;
        logic            inv;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [RW-1:0]   rd;
        logic            ill;
    } exp_t;

    logic            clk = 0, rst_n = 0;
    logic            in_valid, in_ready, in_funct7_b5, flush, out_valid, out_ready;
    logic [6:0]      in_opcode;
    logic [2:0]      in_funct3, out_funct3;
    logic [RW-1:0]   in_rs1, in_rs2, in_rd, ex_fwd_rd, wb_fwd_rd, out_rd;
    logic [XLEN-1:0] in_imm, in_pc, rs1_data, rs2_data, ex_fwd_data, wb_fwd_data;
    logic [XLEN-1:0] out_operand_1, out_operand_2;
    logic            ex_fwd_valid, wb_fwd_valid, out_invert, out_illegal;
    exp_t            q[$];
    int              checks = 0, fails = 0;

    alu_issue_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_b5(in_funct7_b5),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm), .in_pc(in_pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_funct3(out_funct3), .out_invert(out_invert),
        .out_operand_1(out_operand_1), .out_operand_2(out_operand_2),
        .out_rd(out_rd), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] src(input logic [RW-1:0] i, input logic [XLEN-1:0] rf);
        if (i == 0) return '0;
`ifdef ALU_ISSUE_FORWARD_EN
        if (ex_fwd_valid && ex_fwd_rd == i) return ex_fwd_data;
        if (wb_fwd_valid && wb_fwd_rd == i) return wb_fwd_data;
`endif
        return rf;
    endfunction

    function automatic exp_t ref_model();
        exp_t e;
        e = '0;
        e.inv = 1'b1;
        e.rd = in_rd;
        case (in_opcode)
            7'b0110011: begin
                e.f3 = in_funct3; e.op1 = src(in_rs1, rs1_data); e.op2 = src(in_rs2, rs2_data);
                e.inv = (in_funct3 == 3'd0) ? !in_funct7_b5 : (in_funct3 == 3'd5) ? in_funct7_b5 : 1'b0;
            end
            7'b0010011: begin
                e.f3 = in_funct3; e.op1 = src(in_rs1, rs1_data); e.op2 = in_imm;
                e.inv = (in_funct3 == 3'd0) ? 1'b1 : (in_funct3 == 3'd5) ? in_funct7_b5 : 1'b0;
            end
            7'b0110111: e.op2 = in_imm;
            7'b0010111: begin e.op1 = in_pc; e.op2 = in_imm; end
            default: begin e.ill = 1'b1; e.rd = '0; end
        endcase
        return e;
    endfunction

    function automatic bit busy(input logic [RW-1:0] i);
        return i != 0 && ((ex_fwd_valid && ex_fwd_rd == i) || (wb_fwd_valid && wb_fwd_rd == i) ||
                          (q.size() != 0 && q[0].rd == i));
    endfunction

    function automatic bit exp_ready();
        bit stall = 0;
`ifndef ALU_ISSUE_FORWARD_EN
        bit u1 = in_opcode == 7'b0110011 || in_opcode == 7'b0010011;
        bit u2 = in_opcode == 7'b0110011;
        stall = (u1 && busy(in_rs1)) || (u2 && busy(in_rs2));
`endif
        return flush || ((q.size() == 0 || out_ready) && !stall);
    endfunction

    task automatic idle();
        in_valid = 0; in_opcode = 7'b0110011; in_funct3 = 0; in_funct7_b5 = 0;
        in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_imm = 0; in_pc = 0; rs1_data = 0; rs2_data = 0;
        ex_fwd_valid = 0; ex_fwd_rd = 0; ex_fwd_data = 0; wb_fwd_valid = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
        flush = 0; out_ready = 1;
    endtask

    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic b5,
                         input logic [RW-1:0] r1, input logic [RW-1:0] r2, input logic [RW-1:0] rd,
                         input logic [XLEN-1:0] imm);
        in_valid = 1; in_opcode = opc; in_funct3 = f3; in_funct7_b5 = b5;
        in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_imm = imm;
    endtask

    task automatic cycle();
        bit er;
        #1;
        er = exp_ready();
        chk("in_ready", in_ready, er);
        if (in_valid && er && !flush) q.push_back(ref_model());
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, q.size() != 0);
    endtask

    task automatic rand_inputs();
        int p = $urandom_range(0, 9);
        in_valid = $urandom_range(0, 9) < 7;
        in_opcode = p < 4 ? 7'b0110011 : p < 7 ? 7'b0010011 : p == 7 ? 7'b0110111 :
                    p == 8 ? 7'b0010111 : ($urandom_range(0, 1) ? 7'b0000011 : 7'b1100011);
        in_funct3 = 3'($urandom); in_funct7_b5 = 1'($urandom);
        in_rs1 = RW'($urandom_range(0, 3)); in_rs2 = RW'($urandom_range(0, 3)); in_rd = RW'($urandom_range(0, 3));
        in_imm = $urandom; in_pc = $urandom; rs1_data = $urandom; rs2_data = $urandom;
        ex_fwd_valid = $urandom_range(0, 3) == 0; ex_fwd_rd = RW'($urandom_range(0, 3)); ex_fwd_data = $urandom;
        wb_fwd_valid = $urandom_range(0, 3) == 0; wb_fwd_rd = RW'($urandom_range(0, 3)); wb_fwd_data = $urandom;
        flush = $urandom_range(0, 15) == 0; out_ready = $urandom_range(0, 9) < 7;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) chk("out_valid_spurious", out_valid, 0);
            else begin
                chk("out_funct3", out_funct3, q[0].f3);
                chk("out_invert", out_invert, q[0].inv);
                chk("out_operand_1", out_operand_1, q[0].op1);
                chk("out_operand_2", out_operand_2, q[0].op2);
                chk("out_rd", out_rd, q[0].rd);
                chk("out_illegal", out_illegal, q[0].ill);
                if (out_ready || flush) void'(q.pop_front());
            end
        end
    end

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        // Reset while an instruction is held
        issue(7'b0110111, 0, 0, 0, 0, 5, 32'h55); out_ready = 0;
        cycle();
        rst_n = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outputs", {out_funct3, out_invert, out_operand_1, out_operand_2, out_rd, out_illegal}, 0);
        q.delete();
        @(posedge clk);
        #1 rst_n = 1;
        idle();
        #1 chk("rst_in_ready", in_ready, 1);
        // SUB x3 = x1 - x2
        issue(7'b0110011, 3'd0, 1, 1, 2, 3, 0); rs1_data = 10; rs2_data = 3;
        cycle();
        chk("sub_invert", out_invert, 0);
        chk("sub_op1", out_operand_1, 10);
        chk("sub_op2", out_operand_2, 3);
        chk("sub_rd", out_rd, 3);
        idle(); cycle();
`ifdef ALU_ISSUE_FORWARD_EN
        issue(7'b0010011, 3'd0, 0, 5, 0, 6, 1); rs1_data = 32'h11;
        ex_fwd_valid = 1; ex_fwd_rd = 5; ex_fwd_data = 32'hAA;
        wb_fwd_valid = 1; wb_fwd_rd = 5; wb_fwd_data = 32'hBB;
        cycle();
        chk("fwd_ex_wins", out_operand_1, 32'hAA);
        in_rs1 = 0; ex_fwd_rd = 0; wb_fwd_rd = 0;
        cycle();
        chk("fwd_x0_zero", out_operand_1, 0);
`else
        issue(7'b0010011, 3'd0, 0, 4, 0, 6, 1); rs1_data = 32'h44;
        ex_fwd_valid = 1; ex_fwd_rd = 4;
        repeat (3) begin
            #1 chk("stall_in_ready", in_ready, 0);
            cycle();
        end
        ex_fwd_valid = 0;
        cycle();
        chk("stall_release_op1", out_operand_1, 32'h44);
`endif
        idle(); cycle();
        issue(7'b0000011, 3'd2, 0, 1, 2, 7, 32'h123);
        cycle();
        chk("illegal_flag", out_illegal, 1);
        chk("illegal_rd", out_rd, 0);
        // Backpressure then bubble-free refill
        issue(7'b0110111, 0, 0, 0, 0, 1, 32'h1000);
        cycle();
        issue(7'b0110111, 0, 0, 0, 0, 2, 32'h2000); out_ready = 0;
        repeat (3) begin
            cycle();
            chk("bp_hold_rd", out_rd, 1);
        end
        out_ready = 1;
        cycle();
        chk("bp_no_bubble_rd", out_rd, 2);
        // Flush drops held and incoming
        issue(7'b0110011, 3'd0, 0, 1, 2, 9, 0); out_ready = 0; flush = 1;
        #1 chk("flush_in_ready", in_ready, 1);
        cycle();
        flush = 0; out_ready = 1;
        issue(7'b0010111, 0, 0, 0, 0, 4, 32'h2000); in_pc = 32'h100;
        cycle();
        chk("auipc_op1", out_operand_1, 32'h100);
        chk("auipc_op2", out_operand_2, 32'h2000);
        chk("auipc_invert", out_invert, 1);
        chk("auipc_funct3", out_funct3, 0);
        repeat (1500) begin
            rand_inputs();
            cycle();
        end
        idle(); cycle(); cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage directly upstream of the integer ALU.
- Accepts one decoded integer instruction per handshake, resolves source operands (register file, forwarding, PC, immediate) and derives the ALU controls.
- Registers funct3, invert, operand_1, operand_2 and rd for the ALU, with valid/ready flow control and flush.
- Covers OP, OP-IMM, LUI and AUIPC.

Parameters:
XLEN, 32, datapath width (32 or 64)
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  clock
rst_n  in  1  reset
in_valid  in  1  decoded instruction present
in_ready  out  1  stage accepts instruction this cycle
in_opcode  in  7  instruction opcode field
in_funct3  in  3  instruction funct3
in_funct7_b5  in  1  instruction bit 30
in_rs1, in_rs2, in_rd  in  REG_ADDR_W each  register indices
in_imm  in  XLEN  sign-extended immediate (U-type already shifted)
in_pc  in  XLEN  instruction address
rs1_data, rs2_data  in  XLEN  register file read data (combinational, same cycle)
ex_fwd_valid  in  1  EX/MEM holds a result for ex_fwd_rd
ex_fwd_rd  in  REG_ADDR_W  EX/MEM destination
ex_fwd_data  in  XLEN  EX/MEM result
wb_fwd_valid  in  1  writeback writing wb_fwd_rd this cycle
wb_fwd_rd  in  REG_ADDR_W  WB destination
wb_fwd_data  in  XLEN  WB data
flush  in  1  discard held and incoming instruction
out_valid  out  1  ALU inputs valid
out_ready  in  1  downstream consumes this cycle
out_funct3  out  3  ALU funct3
out_invert  out  1  ALU invert
out_operand_1, out_operand_2  out  XLEN  ALU operands
out_rd  out  REG_ADDR_W  destination for writeback
out_illegal  out  1  opcode not in supported set

Behaviour:
- Single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: all registered outputs are 0, including out_valid.
- Single-entry pipeline register. Latency is 1 cycle from accepted input to out_valid.
- in_ready = (!out_valid || out_ready) && !hazard_stall. Transfer occurs when in_valid && in_ready.
- On transfer: output registers load. out_valid=1.
- Else, if out_ready: out_valid=0.
- Else: hold all outputs stable.
- Flush has priority over everything:
  - Next cycle out_valid=0.
  - Any same-cycle incoming instruction is dropped.
  - in_ready reads 1 during flush.
- Operand source for rs1/rs2:
  - Index 0 yields 0; it is never forwarded.
  - Else, if ex_fwd_valid && ex_fwd_rd==idx: ex_fwd_data (EX wins over WB).
  - Else, if wb_fwd_valid && wb_fwd_rd==idx: wb_fwd_data.
  - Else: rs*_data.
- Control derivation (ALU contract: invert=1 selects add for funct3 000; invert=0 subtracts; invert=1 selects arithmetic right shift for funct3 101):
  - OP 0110011: op1=rs1, op2=rs2, funct3=in_funct3.
    - funct3 000: invert=!in_funct7_b5.
    - funct3 101: invert=in_funct7_b5.
    - Otherwise: invert=0.
  - OP-IMM 0010011: op1=rs1, op2=in_imm, funct3=in_funct3.
    - funct3 000: invert=1.
    - funct3 101: invert=in_funct7_b5.
    - Otherwise: invert=0.
  - LUI 0110111: op1=0, op2=in_imm, funct3=000, invert=1.
  - AUIPC 0010111: op1=in_pc, op2=in_imm, funct3=000, invert=1.
  - Any other opcode: out_illegal=1, operands 0, funct3=000, invert=1, out_rd=0 (no architectural write).
- rs2 is not used by OP-IMM, LUI or AUIPC, so no stall on it. rs1 is not used by LUI or AUIPC.
- hazard_stall is always 0 when forwarding is compiled in.

Optional Feature:
- Macro ALU_ISSUE_FORWARD_EN.
- Defined: forwarding as above, no stalls.
- Undefined:
  - Forwarding inputs are ignored; operands come from rs*_data (x0 still reads 0).
  - hazard_stall=1 when a used nonzero source matches ex_fwd_rd with ex_fwd_valid, or wb_fwd_rd with wb_fwd_valid.
  - The stall also applies when out_valid && out_rd equals that source.
  - While stalled, in_ready=0. The held output still drains normally when out_ready.

Decomposition:
- Package alu_issue_pkg:
  - Opcode localparams OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC.
  - ALU funct3 encodings ADD/SL/SLT/SLTU/XOR/SR/OR/AND (shared with the ALU).
  - Typedef for the registered ALU request struct {funct3, invert, op1, op2, rd, illegal}.
- Sub-module operand_fwd_mux: index-0 zeroing plus EX/WB priority select, instantiated twice (rs1, rs2).

Test Plan:
- Reset: rst_n=0 mid-transfer -> out_valid=0, all outputs 0 immediately. Release -> in_ready=1.
- OP SUB x3=x1-x2 (funct7_b5=1, funct3 000, rs1_data=10, rs2_data=3, out_ready=1) -> next cycle out_valid=1, invert=0, op1=10, op2=3, rd=3.
- Forward priority: rs1=5, ex_fwd {1,5,0xAA}, wb_fwd {1,5,0xBB}, rs1_data=0x11 -> op1=0xAA. Repeat with rs1=0 -> op1=0.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, outputs frozen for 3 cycles. Then out_ready=1 -> next instruction loads same cycle, no bubble.
- Flush with in_valid=1, out_valid=1 -> next cycle out_valid=0, incoming dropped. AUIPC pc=0x100 imm=0x2000 after flush -> op1=0x100, op2=0x2000, invert=1.
- Without ALU_ISSUE_FORWARD_EN: ADDI rs1=4 with ex_fwd {1,4} -> in_ready=0 until ex_fwd_valid drops. Opcode 0000011 -> out_illegal=1, rd=0.
